// File: rtl/vc_timer_pkg.sv
// Shared register map and field positions for the vc_timer I/O peripheral.
// Also used by software-facing collateral, so keep indices in sync with the driver.
package vc_timer_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_COUNT   = 3'd1;
    localparam logic [2:0] REG_COMPARE = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CAPTURE = 3'd4;

    localparam int CTRL_EN            = 0;
    localparam int CTRL_PERIODIC      = 1;
    localparam int CTRL_IE_MATCH      = 2;
    localparam int CTRL_IE_OVF        = 3;
    localparam int CTRL_IE_CAP        = 4;
    localparam int CTRL_CAP_FALL      = 5;
    localparam int CTRL_PRESCALE_LSB  = 8;

    localparam int ST_MATCH = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_CAP   = 2;

    localparam logic [15:0] COMPARE_RESET = 16'hFFFF;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by a one-flop edge
// detector; fall_sel picks which transition produces the single-cycle pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic fall_sel,
    output logic pulse
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= 3'b000;
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    // sr[1] is the synchronised pin, sr[2] its previous value
    assign pulse = fall_sel ? (sr[2] & ~sr[1]) : (sr[1] & ~sr[2]);

endmodule

// File: rtl/vc_timer.sv
// Programmable timer/counter for I/O slot 3: prescaled up-counter with compare
// match (periodic or one-shot), overflow flag and external input capture.
module vc_timer
    import vc_timer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       io_addr,
    input  logic             io_write,
    input  logic             io_read,
    input  logic [WIDTH-1:0] io_wdata,
    output logic [WIDTH-1:0] io_rdata,
    input  logic             capture_in,
    output logic             interrupt
);

    logic [2:0]       reg_sel;
    logic             wr_ctrl;
    logic             wr_count;
    logic             wr_compare;
    logic             wr_status;

    logic             en;
    logic             periodic;
    logic             cap_fall;
    logic [2:0]       ie;
    logic [PBITS-1:0] prescale;
    logic [PBITS-1:0] pcnt;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] compare;
    logic [WIDTH-1:0] capture;
    logic [2:0]       status;

    logic             tick;
    logic             hit_match;
    logic             hit_ovf;
    logic             cap_evt;
    logic [2:0]       st_set;
    logic [2:0]       st_clr;
    logic             en_rise;
    logic             unused_inputs;

    assign reg_sel    = io_addr[2:0];
    assign wr_ctrl    = io_write && (reg_sel == REG_CTRL);
    assign wr_count   = io_write && (reg_sel == REG_COUNT);
    assign wr_compare = io_write && (reg_sel == REG_COMPARE);
    assign wr_status  = io_write && (reg_sel == REG_STATUS);

    // Reads have no side effects and only addr[2:0] is decoded
    assign unused_inputs = ^{io_read, io_addr[3]};

    assign tick      = en && (pcnt == prescale);
    assign hit_match = tick && (count == compare);
    assign hit_ovf   = tick && !hit_match && (count == '1);
    assign en_rise   = wr_ctrl && io_wdata[CTRL_EN] && !en;

    assign st_set = {cap_evt, hit_ovf, hit_match};
    assign st_clr = wr_status ? io_wdata[2:0] : 3'b000;

    sync_edge u_cap_sync (
        .clk      (clk),
        .rst_n    (reset),
        .din      (capture_in),
        .fall_sel (cap_fall),
        .pulse    (cap_evt)
    );

    // A CTRL write overrides the one-shot auto-disable landing on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            ie       <= 3'b000;
            cap_fall <= 1'b0;
            prescale <= '0;
        end else if (wr_ctrl) begin
            en       <= io_wdata[CTRL_EN];
            periodic <= io_wdata[CTRL_PERIODIC];
            ie       <= io_wdata[CTRL_IE_CAP:CTRL_IE_MATCH];
            cap_fall <= io_wdata[CTRL_CAP_FALL];
            prescale <= io_wdata[CTRL_PRESCALE_LSB +: PBITS];
        end else if (hit_match && !periodic) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (en_rise || tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (wr_count) begin
            count <= io_wdata;
        end else if (tick) begin
            if (hit_match || hit_ovf) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            compare <= WIDTH'(COMPARE_RESET);
        end else if (wr_compare) begin
            compare <= io_wdata;
        end
    end

    // Hardware set dominates a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status    <= 3'b000;
            capture   <= '0;
            interrupt <= 1'b0;
        end else begin
            status    <= (status & ~st_clr) | st_set;
            interrupt <= |(status & ie);
            if (cap_evt) begin
                capture <= count;
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                io_rdata[CTRL_EN]                     = en;
                io_rdata[CTRL_PERIODIC]               = periodic;
                io_rdata[CTRL_IE_CAP:CTRL_IE_MATCH]   = ie;
                io_rdata[CTRL_CAP_FALL]               = cap_fall;
                io_rdata[CTRL_PRESCALE_LSB +: PBITS]  = prescale;
            end
            REG_COUNT:   io_rdata = count;
            REG_COMPARE: io_rdata = compare;
            REG_STATUS:  io_rdata[2:0] = status;
            REG_CAPTURE: io_rdata = capture;
            default:     io_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_vc_timer.sv
// Directed bench for vc_timer: hand-computed register/interrupt values checked
// with immediate assertions at negedge-aligned sample points.
module tb_vc_timer;

    localparam logic [3:0] A_CTRL    = 4'd0;
    localparam logic [3:0] A_COUNT   = 4'd1;
    localparam logic [3:0] A_COMPARE = 4'd2;
    localparam logic [3:0] A_STATUS  = 4'd3;
    localparam logic [3:0] A_CAPTURE = 4'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  io_addr = '0;
    logic        io_write = 1'b0;
    logic        io_read = 1'b0;
    logic [15:0] io_wdata = '0;
    logic [15:0] io_rdata;
    logic        capture_in = 1'b0;
    logic        interrupt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vc_timer dut (
        .clk        (clk),
        .reset      (reset),
        .io_addr    (io_addr),
        .io_write   (io_write),
        .io_read    (io_read),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .capture_in (capture_in),
        .interrupt  (interrupt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
        io_addr = a;
        io_read = 1'b1;
        #1;
        chk(tag, io_rdata, exp);
        io_read = 1'b0;
    endtask

    task automatic irq(input string tag, input logic exp);
        chk(tag, {15'd0, interrupt}, {15'd0, exp});
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        io_addr  = a;
        io_wdata = d;
        io_write = 1'b1;
        @(negedge clk);
        io_write = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;

        rd("rst_ctrl",    A_CTRL,    16'h0000);
        rd("rst_count",   A_COUNT,   16'h0000);
        rd("rst_compare", A_COMPARE, 16'hFFFF);
        rd("rst_status",  A_STATUS,  16'h0000);
        cyc(1);
        rd("rst_capture", A_CAPTURE, 16'h0000);
        irq("rst_irq", 1'b0);

        // free-run: PRESCALE=3, COMPARE=5, periodic, IE_MATCH
        wr(A_COMPARE, 16'h0005);
        wr(A_CTRL, 16'h0307);
        cyc(19);
        rd("fr_count_e19", A_COUNT, 16'h0004);
        cyc(1);
        rd("fr_count_e20", A_COUNT, 16'h0005);
        rd("fr_status_e20", A_STATUS, 16'h0000);
        cyc(4);
        rd("fr_count_e24", A_COUNT, 16'h0000);
        rd("fr_status_e24", A_STATUS, 16'h0001);
        irq("fr_irq_e24", 1'b0);
        cyc(1);
        irq("fr_irq_e25", 1'b1);
        wr(A_STATUS, 16'h0001);
        rd("fr_w1c_status", A_STATUS, 16'h0000);
        irq("fr_irq_e26", 1'b1);
        cyc(1);
        irq("fr_irq_e27", 1'b0);
        cyc(20);
        rd("fr_count_e47", A_COUNT, 16'h0005);
        rd("fr_status_e47", A_STATUS, 16'h0000);
        cyc(1);
        rd("fr_status_e48", A_STATUS, 16'h0001);
        wr(A_CTRL, 16'h0303);
        irq("fr_irq_e49", 1'b1);
        cyc(1);
        irq("fr_irq_no_ie", 1'b0);
        rd("fr_status_kept", A_STATUS, 16'h0001);
        wr(A_CTRL, 16'h0000);
        wr(A_STATUS, 16'h0007);

        // one-shot: PRESCALE=0, COMPARE=2
        wr(A_COUNT, 16'h0000);
        wr(A_COMPARE, 16'h0002);
        wr(A_CTRL, 16'h0005);
        cyc(2);
        rd("os_count_e2", A_COUNT, 16'h0002);
        rd("os_status_e2", A_STATUS, 16'h0000);
        cyc(1);
        rd("os_count_e3", A_COUNT, 16'h0000);
        rd("os_status_e3", A_STATUS, 16'h0001);
        rd("os_ctrl_e3", A_CTRL, 16'h0004);
        cyc(3);
        rd("os_count_hold", A_COUNT, 16'h0000);
        rd("os_ctrl_hold", A_CTRL, 16'h0004);
        wr(A_STATUS, 16'h0007);

        // overflow and write-1-to-clear
        wr(A_COMPARE, 16'h0010);
        wr(A_COUNT, 16'hFFFE);
        wr(A_CTRL, 16'h000B);
        cyc(1);
        rd("ov_count_e1", A_COUNT, 16'hFFFF);
        rd("ov_status_e1", A_STATUS, 16'h0000);
        cyc(1);
        rd("ov_count_e2", A_COUNT, 16'h0000);
        rd("ov_status_e2", A_STATUS, 16'h0002);
        cyc(1);
        irq("ov_irq_e3", 1'b1);
        wr(A_STATUS, 16'h0002);
        rd("ov_w1c", A_STATUS, 16'h0000);
        irq("ov_irq_e4", 1'b1);
        cyc(1);
        irq("ov_irq_drop", 1'b0);
        cyc(13);
        rd("ov_count_e18", A_COUNT, 16'h0010);
        wr(A_STATUS, 16'h0001);
        rd("ov_set_wins", A_STATUS, 16'h0001);
        rd("ov_match_count", A_COUNT, 16'h0000);
        wr(A_CTRL, 16'h0000);
        wr(A_STATUS, 16'h0007);

        // capture: rising edge, then falling-edge select
        wr(A_COUNT, 16'h0040);
        wr(A_CTRL, 16'hFF11);
        capture_in = 1'b1;
        cyc(2);
        rd("cap_status_c2", A_STATUS, 16'h0000);
        cyc(1);
        rd("cap_status_c3", A_STATUS, 16'h0004);
        rd("cap_value", A_CAPTURE, 16'h0040);
        cyc(1);
        irq("cap_irq", 1'b1);
        wr(A_STATUS, 16'h0004);
        capture_in = 1'b0;
        cyc(4);
        rd("cap_fall_ignored", A_STATUS, 16'h0000);
        rd("cap_value_kept", A_CAPTURE, 16'h0040);
        wr(A_COUNT, 16'h0055);
        wr(A_CTRL, 16'hFF31);
        capture_in = 1'b1;
        cyc(4);
        rd("capf_rise_ignored", A_STATUS, 16'h0000);
        capture_in = 1'b0;
        cyc(2);
        rd("capf_status_c2", A_STATUS, 16'h0000);
        cyc(1);
        rd("capf_status_c3", A_STATUS, 16'h0004);
        rd("capf_value", A_CAPTURE, 16'h0055);
        wr(A_CTRL, 16'h0000);
        wr(A_STATUS, 16'h0007);

        // unmapped registers
        wr(4'd5, 16'hBEEF);
        rd("reg5", 4'd5, 16'h0000);
        rd("reg6", 4'd6, 16'h0000);
        rd("reg7", 4'd7, 16'h0000);
        rd("reg5_alias", 4'hD, 16'h0000);

        // COUNT write on a tick cycle
        wr(A_COUNT, 16'h0000);
        wr(A_COMPARE, 16'hFFFF);
        wr(A_CTRL, 16'h0301);
        cyc(3);
        rd("col_count_e3", A_COUNT, 16'h0000);
        wr(A_COUNT, 16'h1234);
        rd("col_write_wins", A_COUNT, 16'h1234);
        cyc(3);
        rd("col_count_e7", A_COUNT, 16'h1234);
        cyc(1);
        rd("col_count_e8", A_COUNT, 16'h1235);

        // asynchronous reset mid-run
        wr(A_CTRL, 16'h0000);
        wr(A_COUNT, 16'h0000);
        wr(A_COMPARE, 16'h0003);
        wr(A_CTRL, 16'h0007);
        cyc(6);
        rd("ar_count_pre", A_COUNT, 16'h0002);
        irq("ar_irq_pre", 1'b1);
        #1 reset = 1'b0;
        #1;
        irq("ar_irq", 1'b0);
        rd("ar_count", A_COUNT, 16'h0000);
        rd("ar_ctrl", A_CTRL, 16'h0000);
        rd("ar_compare", A_COMPARE, 16'hFFFF);
        rd("ar_status", A_STATUS, 16'h0000);
        rd("ar_capture", A_CAPTURE, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        cyc(5);
        rd("ar_count_idle", A_COUNT, 16'h0000);
        wr(A_CTRL, 16'h0001);
        cyc(2);
        rd("ar_count_resume", A_COUNT, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
